// File: rtl/irq_controller.sv
// Level-interrupt arbiter in front of the core trap logic: masks requests, picks one
// winner (rotating or fixed priority), holds it until mret, then acks the source once.
module irq_controller #(
  parameter int N_SRC       = 16,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] mie_i,
  output logic             irq_o,
  output logic [31:0]      mcause_o,
  input  logic             irq_ret_i,
  output logic [N_SRC-1:0] int_rst_o,
  output logic             busy_o
);

  localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, ACK} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               irq_q, irq_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [N_SRC-1:0]   rst_q, rst_d;
  logic               busy_q, busy_d;

  logic [N_SRC-1:0]   pending;
  logic [IDW-1:0]     win;
  logic               found;
  int                 idx;

  assign pending = int_req_i & mie_i;

  // Winner search: rotating starts just past the last grant, fixed starts at 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (ROUND_ROBIN) begin
      for (int i = 1; i <= N_SRC; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= N_SRC) idx = idx - N_SRC;
        if (!found && pending[IDW'(idx)]) begin
          found = 1'b1;
          win   = IDW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!found && pending[i]) begin
          found = 1'b1;
          win   = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    irq_d    = irq_q;
    mcause_d = mcause_q;
    rst_d    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = ACTIVE;
          id_d     = win;
          if (ROUND_ROBIN) ptr_d = win;
          irq_d    = 1'b1;
          mcause_d = 32'h8000_0010 | 32'(win);
        end
      end
      ACTIVE: begin
        if (irq_ret_i) begin
          state_d = ACK;
          irq_d   = 1'b0;
          for (int k = 0; k < N_SRC; k++) rst_d[k] = (id_q == IDW'(k));
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      ptr_q    <= IDW'(N_SRC - 1);
      irq_q    <= 1'b0;
      mcause_q <= '0;
      rst_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      irq_q    <= irq_d;
      mcause_q <= mcause_d;
      rst_q    <= rst_d;
      busy_q   <= busy_d;
    end
  end

  assign irq_o     = irq_q;
  assign mcause_o  = mcause_q;
  assign int_rst_o = rst_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: rotating, fixed-priority and single-source builds
// side by side, expected values worked out by hand.
module tb_irq_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [15:0] req = '0, mie = '0, rst, rst_f, req_f = '0, mie_f = '0;
  logic        ret = 1'b0, ret_f = 1'b0, irq, irq_f, busy, busy_f;
  logic [31:0] mcause, mcause_f, mcause1;
  logic [0:0]  req1 = '0, mie1 = '0, rst1;
  logic        ret1 = 1'b0, irq1, busy1;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  irq_controller #(.N_SRC(16), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .reset(reset), .int_req_i(req), .mie_i(mie), .irq_o(irq),
    .mcause_o(mcause), .irq_ret_i(ret), .int_rst_o(rst), .busy_o(busy));

  irq_controller #(.N_SRC(16), .ROUND_ROBIN(1'b0)) dut_f (
    .clk(clk), .reset(reset), .int_req_i(req_f), .mie_i(mie_f), .irq_o(irq_f),
    .mcause_o(mcause_f), .irq_ret_i(ret_f), .int_rst_o(rst_f), .busy_o(busy_f));

  irq_controller #(.N_SRC(1), .ROUND_ROBIN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .int_req_i(req1), .mie_i(mie1), .irq_o(irq1),
    .mcause_o(mcause1), .irq_ret_i(ret1), .int_rst_o(rst1), .busy_o(busy1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; drive and sample 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; mie = '0; ret = 1'b0;
    req_f = '0; mie_f = '0; ret_f = 1'b0;
    req1 = '0; mie1 = '0; ret1 = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  int exp_rr[4] = '{0, 2, 0, 2};
  int hcnt, grants, pulses;
  logic irq_prev;

  initial begin
    // Reset state and basic single-source handshake
    do_reset();
    chk("rst_irq", irq, 0);
    chk("rst_cause", mcause, 0);
    chk("rst_ack", rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy1", busy1, 0);
    req = 16'h0001; mie = 16'h0001; req1 = 1'b1; mie1 = 1'b1;
    chk("pre_irq", irq, 0);
    tick();
    chk("lat_irq", irq, 1);
    chk("lat_cause", mcause, 32'h8000_0010);
    chk("lat_busy", busy, 1);
    chk("n1_irq", irq1, 1);
    chk("n1_cause", mcause1, 32'h8000_0010);
    ret = 1'b1; ret1 = 1'b1;
    tick();
    ret = 1'b0; ret1 = 1'b0;
    chk("ack_rst", rst, 16'h0001);
    chk("ack_irq", irq, 0);
    chk("ack_busy", busy, 1);
    chk("n1_ack", rst1, 1);
    req = '0; req1 = '0;
    tick();
    chk("idle_rst", rst, 0);
    chk("idle_busy", busy, 0);
    chk("idle_cause_hold", mcause, 32'h8000_0010);
    chk("n1_idle_rst", rst1, 0);
    tick();
    chk("idle_no_regrant", irq, 0);

    // Rotating vs fixed priority with sources 0 and 2 re-raising
    do_reset();
    req = 16'h0005; mie = 16'hFFFF; req_f = 16'h0005; mie_f = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_cause", mcause, 32'h8000_0010 | exp_rr[k]);
      chk("fp_cause", mcause_f, 32'h8000_0010);
      ret = 1'b1; ret_f = 1'b1;
      tick();
      ret = 1'b0; ret_f = 1'b0;
      chk("rr_ack", rst, 32'(16'(1 << exp_rr[k])));
      chk("fp_ack", rst_f, 32'h1);
      chk("rr_ack_irq", irq, 0);
      req = req & ~rst; req_f = req_f & ~rst_f;
      tick();
      req = req | 16'(1 << exp_rr[k]); req_f = req_f | 16'h0001;
    end

    // Masking
    do_reset();
    req = 16'h0008;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("mask_irq", irq, 0);
    end
    mie = 16'h0008;
    tick();
    chk("unmask_irq", irq, 1);
    chk("unmask_cause", mcause, 32'h8000_0013);
    mie = '0; req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_irq", irq, 1);
      chk("hold_cause", mcause, 32'h8000_0013);
    end
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("mask_ack", rst, 16'h0008);
    chk("mask_ack_irq", irq, 0);
    tick();

    // Keyboard model on bit 0: event every 16 cycles, handler acks after 3 cycles
    do_reset();
    mie = 16'h0001;
    hcnt = 0; grants = 0; pulses = 0; irq_prev = 1'b0;
    for (int cyc = 0; cyc < 96; cyc++) begin
      if (cyc % 16 == 0 && cyc < 80) req[0] = 1'b1;
      tick();
      if (irq && !irq_prev) grants++;
      irq_prev = irq;
      if (rst != 0) begin
        pulses++;
        chk("kb_ack_irq", irq, 0);
        chk("kb_ack_onehot", rst, 16'h0001);
        req[0] = 1'b0;
      end
      ret = 1'b0;
      if (irq) begin
        hcnt++;
        if (hcnt == 3) ret = 1'b1;
      end else hcnt = 0;
    end
    chk("kb_grants", grants, 5);
    chk("kb_pulses", pulses, 5);

    // Reset during ACTIVE with a simultaneous mret
    do_reset();
    req = 16'h0002; mie = 16'hFFFF;
    tick();
    chk("pre_rst_cause", mcause, 32'h8000_0011);
    reset = 1'b1; ret = 1'b1; req = '0;
    tick();
    reset = 1'b0; ret = 1'b0;
    chk("midrst_irq", irq, 0);
    chk("midrst_ack", rst, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cause", mcause, 0);
    tick();
    chk("midrst_no_ack", rst, 0);
    req = 16'h0006;
    tick();
    chk("post_rst_irq", irq, 1);
    chk("post_rst_cause", mcause, 32'h8000_0011);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller between the memory-mapped peripherals (keyboard and later devices) and the RISC-V core's trap logic.
- Collects level interrupt requests and applies the core's enable mask.
- Selects one winner by round-robin or fixed priority and presents one interrupt at a time to the core with its mcause.
- When the core returns from the handler, issues a one-cycle acknowledge to the serviced peripheral so that it clears its interrupt flop.

Parameters:
- N_SRC, 16, number of interrupt sources; legal range 1..16.
- ROUND_ROBIN, 1, selection policy: 1 = rotating priority, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- int_req_i  input  N_SRC  level interrupt requests; bit k = peripheral k (keyboard kb_int_o on bit 0).
- mie_i  input  N_SRC  per-source enable mask from the CSR unit.
- irq_o  output  1  interrupt request to the core.
- mcause_o  output  32  cause value for the pending interrupt.
- irq_ret_i  input  1  one-cycle pulse from the core on mret (handler done).
- int_rst_o  output  N_SRC  one-hot, one-cycle acknowledge to the serviced source (drives kb_int_rst_i).
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: FSM = IDLE; irq_o = 0; mcause_o = 0; int_rst_o = 0; busy_o = 0; grant id = 0; rr pointer = N_SRC-1, so source 0 is searched first.
- Reset mid-operation: return to the reset values immediately; no acknowledge pulse is issued.
- pending = int_req_i & mie_i, evaluated only in IDLE.
- FSM states: IDLE, ACTIVE, ACK. All outputs are registered.
- IDLE:
  - If pending != 0: choose winner w, latch id <= w, go to ACTIVE.
  - On that same edge: irq_o <= 1 and mcause_o <= 32'h8000_0010 | w.
  - Latency: 1 clock from a pending bit sampled high to irq_o high.
  - irq_ret_i is ignored in IDLE.
- ROUND_ROBIN = 1:
  - Search order is ptr+1, ptr+2, ... modulo N_SRC, wrapping up to and including ptr; the first pending bit wins.
  - ptr <= w on entering ACTIVE.
- ROUND_ROBIN = 0: the lowest-index pending bit wins; ptr is not used.
- ACTIVE:
  - irq_o = 1; mcause_o is held stable.
  - Changes on int_req_i or mie_i are ignored, including the winner dropping its request or being masked.
  - On irq_ret_i = 1: go to ACK, with irq_o <= 0 and int_rst_o <= one-hot(id).
- ACK:
  - int_rst_o is high for exactly this one cycle; irq_o = 0.
  - Next state is IDLE with int_rst_o <= 0.
  - The peripheral clears its request at the end of the ACK cycle, so IDLE never re-grants the same event.
- Minimum spacing between two grants is 3 cycles: ACTIVE, ACK, IDLE.
- mcause_o keeps its last value after ACK; the core only samples it while irq_o = 1.
- If irq_ret_i is held high for several cycles, only the first cycle in ACTIVE has effect.
- N_SRC = 1: both policies degenerate to a single source; ptr logic must still synthesize.
- Simultaneous irq_ret_i and a new request during ACTIVE: the ACK completes first, and the new request is evaluated in the following IDLE cycle.

Test Plan:
- Reset, then int_req_i = 0x0001, mie_i = 0x0001 → irq_o = 1 exactly 1 clock later, mcause_o = 0x8000_0010, busy_o = 1. Pulse irq_ret_i → int_rst_o = 0x0001 for one cycle, then IDLE.
- ROUND_ROBIN = 1, int_req_i = 0x0005 held, mie_i = 0xFFFF, each grant acked and each serviced source re-raised after its ack → grant order is sources 0, 2, 0, 2 (mcause_o 0x10, 0x12, 0x10, 0x12).
- ROUND_ROBIN = 0, same stimulus → every grant is source 0 (mcause_o 0x8000_0010); source 2 is starved as long as source 0 re-raises.
- Masking: int_req_i = 0x0008, mie_i = 0x0000 → irq_o stays 0 for 10 cycles. Set mie_i = 0x0008 → irq_o = 1 with mcause_o = 0x8000_0013. Then clear mie_i while ACTIVE → irq_o stays 1 until irq_ret_i.
- Keyboard model (interrupt every 16 cycles, cleared by int_rst) on bit 0: 5 handler cycles each acked → exactly 5 int_rst_o pulses, no duplicate grant, irq_o low during every ACK cycle.
- Reset asserted during ACTIVE with irq_ret_i pulsed in the same cycle → next cycle irq_o = 0, int_rst_o = 0, busy_o = 0. The next grant with int_req_i = 0x0006 is source 1.
